ek_encode: RTL and testbench



---
 rtl/ek_encode_pkg.sv | 14 +
 rtl/ek_encode_byte_encode12_group.sv | 21 ++
 rtl/ek_encode.sv | 115 +++++++++++
 tb/tb_ek_encode.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ek_encode_pkg.sv
// Shared ML-KEM sizes and types for the encapsulation-key serializer.
// The parameter set is chosen here; ML_KEM_K = 2 is ML-KEM-512.
package ek_encode_pkg;
  localparam int ML_KEM_K     = 2;
  localparam int ML_KEM_N     = 256;
  localparam int ML_KEM_LEN_Q = 12;
  localparam int POLY_WORDS   = 48 * ML_KEM_K;
  localparam int EK_WORDS     = POLY_WORDS + 4;

  typedef logic [ML_KEM_N-1:0][ML_KEM_LEN_Q-1:0] poly_t;
  typedef poly_t [ML_KEM_K-1:0] polyvec_t;

  typedef enum logic [1:0] {ST_IDLE, ST_POLY, ST_RHO, ST_FIN} ek_state_e;
endpackage

// File: rtl/ek_encode_byte_encode12_group.sv
// ByteEncode12 of one 16-coefficient group (192 bits) into three 64-bit words.
// coeff_i[0] lands in bits [11:0] of sub-word 0; sub_i = 3 yields zero.
module byte_encode12_group
  import ek_encode_pkg::*;
(
  input  logic [15:0][ML_KEM_LEN_Q-1:0] coeff_i,
  input  logic [1:0]                    sub_i,
  output logic [63:0]                   word_o
);
  logic [191:0] grp;
  assign grp = coeff_i;

  always_comb begin
    case (sub_i)
      2'd0:    word_o = grp[63:0];
      2'd1:    word_o = grp[127:64];
      2'd2:    word_o = grp[191:128];
      default: word_o = '0;
    endcase
  end
endmodule

// File: rtl/ek_encode.sv
// Encapsulation-key serializer: ByteEncode12(t_hat) || rho as 64-bit LE words.
// The output register is loaded with the word for the *next* counter value.
module ek_encode
  import ek_encode_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         run_i,
  input  polyvec_t     t_hat_i,
  input  logic [255:0] rho_i,
  output logic [63:0]  data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         last_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam int PW = (ML_KEM_K > 1) ? $clog2(ML_KEM_K) : 1;

  ek_state_e   state_q, state_d;
  logic [6:0]  w_q, w_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d, last_q, last_d;
  logic        hs, load, clr;

  logic [6:0]  p_idx, m_idx;
  logic [3:0]  g_idx;
  logic [1:0]  s_idx, rk;
  logic [PW-1:0] pi;
  logic [15:0][ML_KEM_LEN_Q-1:0] grp;
  logic [63:0] enc_word, nxt_word;

  assign hs = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    valid_d = valid_q;
    last_d  = last_q;
    load    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (run_i) begin
        state_d = ST_POLY;
        w_d     = '0;
        valid_d = 1'b1;
        load    = 1'b1;
      end
      ST_POLY, ST_RHO: if (hs) begin
        if (w_q == 7'(EK_WORDS - 1)) begin
          state_d = ST_FIN;
          valid_d = 1'b0;
          last_d  = 1'b0;
          clr     = 1'b1;
        end else begin
          w_d  = w_q + 7'd1;
          load = 1'b1;
          if (w_q == 7'(POLY_WORDS - 1)) state_d = ST_RHO;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        w_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) last_d = (w_d == 7'(EK_WORDS - 1));
  end

  // Word address decode: polynomial, 16-coefficient group, sub-word, rho lane.
  always_comb begin
    p_idx = w_d / 7'd48;
    m_idx = w_d % 7'd48;
    g_idx = 4'(m_idx / 7'd3);
    s_idx = 2'(m_idx % 7'd3);
    pi    = p_idx[PW-1:0];
    rk    = 2'(w_d - 7'(POLY_WORDS));
    grp   = t_hat_i[pi][{g_idx, 4'b0000} +: 16];
  end

  byte_encode12_group u_grp (
    .coeff_i (grp),
    .sub_i   (s_idx),
    .word_o  (enc_word)
  );

  always_comb begin
    nxt_word = (w_d < 7'(POLY_WORDS)) ? enc_word : rho_i[{rk, 6'b000000} +: 64];
    data_d   = data_q;
    if (load)     data_d = nxt_word;
    else if (clr) data_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = (state_q == ST_POLY) || (state_q == ST_RHO);
  assign done_o  = (state_q == ST_FIN);
endmodule

// File: tb/tb_ek_encode.sv
// Directed/table-driven bench for ek_encode against a bit-serial ByteEncode12 model.
module tb_ek_encode;
  import ek_encode_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n_i, run_i, ready_i;
  polyvec_t     th;
  logic [255:0] rh;
  logic [63:0]  data_o;
  logic         valid_o, last_o, busy_o, done_o;

  ek_encode dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .run_i(run_i), .t_hat_i(th), .rho_i(rh),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [63:0] exp;
    bit          last;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0, n_err = 0;
  logic [63:0] got_data[128];
  bit          got_last[128];
  int          n_got, done_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Treats t_hat as one flat little-endian bitstream of 12-bit fields.
  function automatic logic [63:0] model_word(input int w);
    logic [63:0] r;
    for (int j = 0; j < 64; j++) begin
      int bp = 64 * w + j;
      if (bp < ML_KEM_K * 3072) begin
        int p = bp / 3072;
        int q = bp % 3072;
        r[j] = th[p][q / 12][q % 12];
      end else begin
        r[j] = rh[bp - ML_KEM_K * 3072];
      end
    end
    return r;
  endfunction

  task automatic run_stream(input bit start, input bit rnd, input bit poke, input bit chain);
    int cyc = 0, stall = 0;
    bit stall_used = 0, prev_stall = 0;
    logic [63:0] prev = '0;
    n_got = 0;
    done_cyc = -1;
    if (start) run_i = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      run_i = 1'b0;
      if (cyc == 1) chk("busy_after_run", 64'(busy_o), 64'd1);
      if (poke && cyc == 20) run_i = 1'b1;
      if (done_o) begin
        done_cyc = cyc;
        chk("valid_in_done_cycle", 64'(valid_o), 64'd0);
        if (poke) run_i = 1'b1;
        break;
      end
      if (rnd) begin
        if (n_got == 10 && !stall_used) begin
          stall_used = 1;
          stall = 5;
        end
        if (stall > 0) begin
          ready_i = 1'b0;
          stall--;
        end else begin
          ready_i = 1'($urandom_range(0, 1));
        end
      end else begin
        ready_i = 1'b1;
      end
      if (prev_stall) chk($sformatf("stall_stable_w%0d", n_got), data_o, prev);
      if (valid_o && ready_i && n_got < 128) begin
        got_data[n_got] = data_o;
        got_last[n_got] = last_o;
        n_got++;
      end
      prev_stall = valid_o && !ready_i;
      prev = data_o;
    end
    if (done_cyc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done_o, required one within 3000 cycles");
    end
    @(negedge clk);
    run_i = chain;
    chk("post_done_idle", 64'(valid_o), 64'd0);
    if (!chain) begin
      @(negedge clk);
      chk("no_restart", 64'(valid_o), 64'd0);
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 64'(n_got), 64'(EK_WORDS));
    for (int i = 0; i < EK_WORDS; i++) begin
      chk($sformatf("%s_w%0d", tag, i), got_data[i], model_word(i));
      chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == EK_WORDS - 1));
    end
  endtask

  task automatic apply_tbl(input string tag);
    foreach (tbl[i]) begin
      chk($sformatf("%s_tbl_w%0d", tag, tbl[i].idx), got_data[tbl[i].idx], tbl[i].exp);
      chk($sformatf("%s_tbl_last%0d", tag, tbl[i].idx), 64'(got_last[tbl[i].idx]), 64'(tbl[i].last));
    end
    tbl.delete();
  endtask

  initial begin
    rst_n_i = 1'b0;
    run_i   = 1'b0;
    ready_i = 1'b0;
    th      = '0;
    rh      = '0;
    for (int i = 0; i < 32; i++) rh[8*i +: 8] = 8'(i);

    repeat (2) @(negedge clk);
    chk("rst_data", data_o, 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst_n_i = 1'b1;
    @(negedge clk);

    // Zero coefficients, rho byte i = i, full-rate sink.
    run_stream(1, 0, 0, 0);
    chk("zero_latency", 64'(done_cyc), 64'(EK_WORDS + 1));
    tbl.push_back('{0,  64'h0, 0});
    tbl.push_back('{95, 64'h0, 0});
    tbl.push_back('{96, 64'h0706050403020100, 0});
    tbl.push_back('{97, 64'h0F0E0D0C0B0A0908, 0});
    tbl.push_back('{98, 64'h1716151413121110, 0});
    tbl.push_back('{99, 64'h1F1E1D1C1B1A1918, 1});
    apply_tbl("zero");
    check_stream("zero");

    // Sparse coefficients hitting word and group boundaries.
    th[0][0]  = 12'hABC;
    th[0][1]  = 12'h123;
    th[0][5]  = 12'h5A5;
    th[0][15] = 12'hEDC;
    th[0][16] = 12'h777;
    th[1][0]  = 12'hFFF;
    run_stream(1, 0, 0, 0);
    tbl.push_back('{0,  64'h5000000000123ABC, 0});
    tbl.push_back('{1,  64'h000000000000005A, 0});
    tbl.push_back('{2,  64'hEDC0000000000000, 0});
    tbl.push_back('{3,  64'h0000000000000777, 0});
    tbl.push_back('{48, 64'h0000000000000FFF, 0});
    apply_tbl("sparse");

    // Saturated coefficients.
    th = '1;
    run_stream(1, 0, 0, 0);
    tbl.push_back('{0,  64'hFFFFFFFFFFFFFFFF, 0});
    tbl.push_back('{47, 64'hFFFFFFFFFFFFFFFF, 0});
    tbl.push_back('{95, 64'hFFFFFFFFFFFFFFFF, 0});
    tbl.push_back('{99, 64'h1F1E1D1C1B1A1918, 1});
    apply_tbl("ones");
    check_stream("ones");

    // Random data, random backpressure with a 5-cycle stall at w = 10.
    for (int p = 0; p < ML_KEM_K; p++)
      for (int i = 0; i < ML_KEM_N; i++) th[p][i] = 12'($urandom);
    for (int i = 0; i < 8; i++) rh[32*i +: 32] = $urandom;
    run_stream(1, 1, 0, 0);
    check_stream("rand");

    // Reset while word 50 is presented.
    ready_i = 1'b1;
    run_i   = 1'b1;
    n_got   = 0;
    for (int c = 0; c < 200 && n_got < 50; c++) begin
      @(negedge clk);
      run_i = 1'b0;
      if (valid_o && ready_i) n_got++;
    end
    @(negedge clk);
    rst_n_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_data", data_o, 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_last", 64'(last_o), 64'd0);
    @(negedge clk);
    chk("midrst_no_resume", 64'(valid_o), 64'd0);
    run_stream(1, 0, 0, 0);
    check_stream("after_rst");

    // run_i during POLY and in the done cycle is ignored.
    run_stream(1, 0, 1, 0);
    chk("poke_latency", 64'(done_cyc), 64'(EK_WORDS + 1));
    check_stream("poke");

    // run_i one cycle after done_o starts a fresh stream.
    run_stream(1, 0, 0, 1);
    run_stream(0, 0, 0, 0);
    chk("chain_latency", 64'(done_cyc), 64'(EK_WORDS + 1));
    check_stream("chain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
